// File: rtl/i2c_target_pkg.sv
// Shared types and constants for the simulation-only I2C target model.
package i2c_target_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        WR_DATA,
        RD_DATA,
        RD_ACK,
        IGNORE
    } i2c_tgt_state_e;

    localparam logic I2cAck  = 1'b0;
    localparam logic I2cNack = 1'b1;

    // The general call address never matches, even if the target address is set to 0.
    function automatic logic addr_match(input logic [6:0] addr, input logic [6:0] target);
        return (addr == target) && (addr != 7'h00);
    endfunction

endpackage

// File: rtl/i2c_target_sync.sv
// Two-flop synchronizers for SCL/SDA plus registered edge and START/STOP detection.
module i2c_target_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_sync,
    output logic sda_sync,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [1:0] scl_ff;
    logic [1:0] sda_ff;

    // scl_sync/sda_sync are the previous synchronized samples, so they line up with the
    // registered detect pulses. START/STOP need SCL high in both samples, which makes a
    // simultaneous SCL and SDA change count as a data change.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            scl_ff    <= 2'b11;
            sda_ff    <= 2'b11;
            scl_sync  <= 1'b1;
            sda_sync  <= 1'b1;
            scl_rise  <= 1'b0;
            scl_fall  <= 1'b0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
        end else begin
            scl_ff    <= {scl_ff[0], scl_i};
            sda_ff    <= {sda_ff[0], sda_i};
            scl_sync  <= scl_ff[1];
            sda_sync  <= sda_ff[1];
            scl_rise  <= scl_ff[1] & ~scl_sync;
            scl_fall  <= ~scl_ff[1] & scl_sync;
            start_det <= scl_ff[1] & scl_sync & sda_sync & ~sda_ff[1];
            stop_det  <= scl_ff[1] & scl_sync & ~sda_sync & sda_ff[1];
        end
    end

endmodule

// File: rtl/i2c_target_model.sv
// I2C target with an auto-incrementing register pointer; only ever pulls SDA low and
// never stretches SCL.
module i2c_target_model
    import i2c_target_pkg::*;
#(
    parameter logic [6:0] TargetAddr = 7'h50,
    parameter int          NumRegs    = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       scl_i,
    input  logic                       sda_i,
    output logic                       sda_en_o,
    output logic                       busy_o,
    output logic                       reg_wr_o,
    output logic [$clog2(NumRegs)-1:0] reg_addr_o,
    output logic [7:0]                 reg_wdata_o
);

    localparam int PtrW = $clog2(NumRegs);

    logic scl_sync;
    logic sda_sync;
    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;

    i2c_target_sync u_sync (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .scl_i     (scl_i),
        .sda_i     (sda_i),
        .scl_sync  (scl_sync),
        .sda_sync  (sda_sync),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    i2c_tgt_state_e  state;
    logic [3:0]      bit_cnt;
    logic [7:0]      shift;
    logic [PtrW-1:0] ptr;
    logic            rd_mode;
    logic [7:0]      regs [NumRegs];

    logic [7:0] rx_byte;
    logic       sample_edge;

    assign rx_byte     = {shift[6:0], sda_sync};
    assign sample_edge = scl_rise & scl_sync;

    // In the receive states bit_cnt reaches 8 on the 8th SCL rise; the following fall
    // drives ACK and the fall after that (sda_en_o already set) ends the byte.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            bit_cnt     <= 4'd0;
            shift       <= 8'h00;
            ptr         <= '0;
            rd_mode     <= 1'b0;
            sda_en_o    <= 1'b0;
            busy_o      <= 1'b0;
            reg_wr_o    <= 1'b0;
            reg_addr_o  <= '0;
            reg_wdata_o <= 8'h00;
            for (int i = 0; i < NumRegs; i++) begin
                regs[i] <= 8'h00;
            end
        end else begin
            reg_wr_o <= 1'b0;
            if (stop_det) begin
                state    <= IDLE;
                sda_en_o <= 1'b0;
                busy_o   <= 1'b0;
                bit_cnt  <= 4'd0;
            end else if (start_det) begin
                state    <= ADDR;
                sda_en_o <= 1'b0;
                bit_cnt  <= 4'd0;
            end else begin
                case (state)
                    ADDR: begin
                        if (sample_edge) begin
                            shift   <= rx_byte;
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                if (addr_match(rx_byte[7:1], TargetAddr)) begin
                                    state   <= ADDR_ACK;
                                    rd_mode <= rx_byte[0];
                                    busy_o  <= 1'b1;
                                end else begin
                                    state <= IGNORE;
                                end
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (scl_fall) begin
                            if (!sda_en_o) begin
                                sda_en_o <= ~I2cAck;
                            end else begin
                                bit_cnt <= 4'd0;
                                if (rd_mode) begin
                                    state    <= RD_DATA;
                                    shift    <= regs[ptr];
                                    sda_en_o <= ~regs[ptr][7];
                                end else begin
                                    state    <= PTR;
                                    sda_en_o <= 1'b0;
                                end
                            end
                        end
                    end
                    PTR, WR_DATA: begin
                        if (sample_edge && bit_cnt != 4'd8) begin
                            shift   <= rx_byte;
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                if (state == PTR) begin
                                    ptr <= rx_byte[PtrW-1:0];
                                end else begin
                                    regs[ptr]   <= rx_byte;
                                    reg_wr_o    <= 1'b1;
                                    reg_addr_o  <= ptr;
                                    reg_wdata_o <= rx_byte;
                                    ptr         <= ptr + 1'b1;
                                end
                            end
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            if (!sda_en_o) begin
                                sda_en_o <= ~I2cAck;
                            end else begin
                                sda_en_o <= 1'b0;
                                bit_cnt  <= 4'd0;
                                state    <= WR_DATA;
                            end
                        end
                    end
                    RD_DATA: begin
                        if (sample_edge && bit_cnt != 4'd8) begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                sda_en_o <= 1'b0;
                                state    <= RD_ACK;
                                ptr      <= ptr + 1'b1;
                            end else if (bit_cnt != 4'd0) begin
                                sda_en_o <= ~shift[6];
                                shift    <= {shift[6:0], 1'b0};
                            end
                        end
                    end
                    RD_ACK: begin
                        // bit_cnt drops to 0 once the host has ACKed, arming the next byte.
                        if (sample_edge) begin
                            if (sda_sync == I2cNack) begin
                                state <= IGNORE;
                            end else begin
                                bit_cnt <= 4'd0;
                            end
                        end else if (scl_fall && bit_cnt == 4'd0) begin
                            state    <= RD_DATA;
                            shift    <= regs[ptr];
                            sda_en_o <= ~regs[ptr][7];
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
